// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared definitions for the instruction fetch unit
//
// Purpose: FSM state encodings, Branch field encodings and default
//          reset/trap PC values used by instr_fetch_unit and npc_calc.
// Ports:   none (package).

package fetch_pkg;

  // FSM state encoding. ST_TRAP is only reachable in IF_TRAP_EN builds.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_FETCH = 2'd0;
  localparam fsm_state_t ST_EXEC  = 2'd1;
  localparam fsm_state_t ST_TRAP  = 2'd2;

  // Branch field from the control unit
  typedef logic [1:0] branch_t;
  localparam branch_t BR_SEQ = 2'b00;
  localparam branch_t BR_BEQ = 2'b01;
  localparam branch_t BR_J   = 2'b10;
  localparam branch_t BR_JR  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0180;

  // A fetch target is misaligned when it is not on a word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC selection
//
// Purpose: computes PC+4 and the next PC from the Branch field, the ALU
//          zero flag, the instruction's immediate / jump index and rs_data.
// Ports:
//   pc          in  [31:0]  current PC
//   instr_index in  [25:0]  IR[25:0] (jump index; IR[15:0] is the beq offset)
//   branch      in  [1:0]   BR_SEQ / BR_BEQ / BR_J / BR_JR
//   zero        in          ALU zero flag (beq taken when set)
//   rs_data     in  [31:0]  jr target
//   pc_plus4    out [31:0]  PC+4, also the jal link value
//   npc         out [31:0]  selected next PC

module npc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic [1:0]  branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc
);

  logic [31:0] br_offset;

  // All additions are 32-bit and wrap naturally.
  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (branch)
      BR_SEQ: npc = pc_plus4;
      BR_BEQ: npc = zero ? (pc_plus4 + br_offset) : pc_plus4;
      BR_J:   npc = {pc_plus4[31:28], instr_index, 2'b00};
      BR_JR:  npc = rs_data;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle instruction fetch unit with PC/IR
//
// Purpose: fetches an instruction at PC, holds it in IR while the datapath
//          executes it, then advances PC to the selected next PC.
//          Optional macro IF_TRAP_EN: a misaligned next PC enters a one-cycle
//          TRAP state and redirects fetch to TRAP_VECTOR.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  instruction read request and address (= PC)
//   imem_data/ready     returned instruction word and its valid strobe
//   OPcode, Fun         IR[31:26] and IR[5:0] for the control unit
//   inst_out            IR
//   inst_valid          IR holds the instruction being executed
//   Branch, zero        next-PC select from control unit / ALU
//   rs_data             jr target
//   exec_done           datapath finished the current instruction
//   pc_out, pc_plus4    current PC and PC+4
//   trap                one-cycle trap pulse (tied 0 without IF_TRAP_EN)

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic [5:0]  OPcode,
  output logic [5:0]  Fun,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  input  logic [1:0]  Branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        exec_done,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        trap
);

  fsm_state_t  state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] npc;

  npc_calc u_npc_calc (
    .pc          (pc),
    .instr_index (ir[25:0]),
    .branch      (Branch),
    .zero        (zero),
    .rs_data     (rs_data),
    .pc_plus4    (pc_plus4),
    .npc         (npc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= 32'h0000_0000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
`ifdef IF_TRAP_EN
            // PC is left at the faulting instruction for the trap cycle.
            if (is_misaligned(npc)) begin
              state <= ST_TRAP;
            end else begin
              pc    <= npc;
              state <= ST_FETCH;
            end
`else
            pc    <= npc;
            state <= ST_FETCH;
`endif
          end
        end
`ifdef IF_TRAP_EN
        ST_TRAP: begin
          pc    <= TRAP_VECTOR;
          state <= ST_FETCH;
        end
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  // State is already FETCH while reset is held, so the request is also
  // qualified by rst_n to keep it low during reset.
  assign imem_req   = rst_n && (state == ST_FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == ST_EXEC);
  assign inst_out   = ir;
  assign OPcode     = ir[31:26];
  assign Fun        = ir[5:0];
  assign pc_out     = pc;

`ifdef IF_TRAP_EN
  assign trap = (state == ST_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard testbench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0180;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [5:0]  OPcode;
  logic [5:0]  Fun;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic [1:0]  Branch;
  logic        zero;
  logic [31:0] rs_data;
  logic        exec_done;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        trap;

  instr_fetch_unit #(
    .RESET_PC    (RST_PC),
    .TRAP_VECTOR (TRAP_VEC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .OPcode     (OPcode),
    .Fun        (Fun),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .Branch     (Branch),
    .zero       (zero),
    .rs_data    (rs_data),
    .exec_done  (exec_done),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_ir_t;

  logic [31:0] exp_addr_q[$];
  exp_ir_t     exp_ir_q[$];
  logic [31:0] m_pc;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules.
  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [1:0] br, input logic z,
                                          input logic [31:0] rs);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = 32'($signed(instr[15:0])) * 32'd4;
    case (br)
      2'd0: return seq;
      2'd1: return z ? seq + off : seq;
      2'd2: return (seq & 32'hF000_0000) | (32'(instr[25:0]) * 32'd4);
      default: return rs;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT accepts a fetch or starts executing.
  initial begin
    logic prev_valid;
    exp_ir_t e;
    logic [31:0] a;
    prev_valid = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rst_n && imem_req && imem_ready) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
        end else begin
          a = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr, a);
        end
      end
      if (rst_n && inst_valid && !prev_valid) begin
        if (exp_ir_q.size() == 0) begin
          chk("unexpected_exec", inst_out, 32'hxxxx_xxxx);
        end else begin
          e = exp_ir_q.pop_front();
          chk("ir", inst_out, e.ir);
          chk("opcode", 32'(OPcode), 32'(e.ir[31:26]));
          chk("fun", 32'(Fun), 32'(e.ir[5:0]));
          chk("exec_pc", pc_out, e.pc);
          chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
      prev_valid = rst_n && inst_valid;
    end
  end

  // One instruction: fetch after rdy_dly wait cycles, execute for exe_dly cycles.
  task automatic step(input logic [31:0] instr, input logic [1:0] br, input logic z,
                      input logic [31:0] rs, input int rdy_dly, input int exe_dly);
    logic [31:0] npc;
    exp_addr_q.push_back(m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready = 1'b0;
      imem_data  = $urandom;
      exec_done  = 1'($urandom_range(0, 1));
      Branch     = 2'($urandom);
      zero       = 1'($urandom);
      rs_data    = $urandom;
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      @(posedge clk); #1;
    end
    exec_done  = 1'b0;
    imem_ready = 1'b1;
    imem_data  = instr;
    exp_ir_q.push_back('{instr, m_pc});
    @(negedge clk);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr_hold", imem_addr, m_pc);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_data  = $urandom;
    for (int i = 0; i < exe_dly; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_data  = $urandom;
      Branch     = 2'($urandom);
      zero       = 1'($urandom);
      rs_data    = $urandom;
      @(negedge clk);
      chk("exec_valid", 32'(inst_valid), 32'd1);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_pc_hold", pc_out, m_pc);
      chk("exec_ir_hold", inst_out, instr);
      chk("exec_trap", 32'(trap), 32'd0);
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    Branch     = br;
    zero       = z;
    rs_data    = rs;
    exec_done  = 1'b1;
    npc = ref_npc(m_pc, instr, br, z, rs);
    @(posedge clk); #1;
    exec_done = 1'b0;
`ifdef IF_TRAP_EN
    if (npc[1:0] != 2'b00) begin
      @(negedge clk);
      chk("trap_pulse", 32'(trap), 32'd1);
      chk("trap_pc_hold", pc_out, m_pc);
      chk("trap_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
      npc = TRAP_VEC;
    end
`endif
    m_pc = npc;
  endtask

  // Checks the fetch address presented in the FETCH cycle against a fixed value.
  task automatic expect_next(input string name, input logic [31:0] addr);
    imem_ready = 1'b0;
    @(negedge clk);
    chk(name, imem_addr, addr);
    chk("trap_low", 32'(trap), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rs;
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    imem_data  = 32'hDEAD_BEEF;
    exec_done  = 1'b0;
    Branch     = 2'b00;
    zero       = 1'b0;
    rs_data    = 32'h0;
    m_pc       = RST_PC;

    // Reset state with imem_ready held high
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_ir", inst_out, 32'h0);
    chk("rst_opcode", 32'(OPcode), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add at 0, sequential -> 4 (one-cycle fetch latency)
    step(32'h0000_0020, 2'b00, 1'b0, 32'h0, 0, 2);
    expect_next("seq_next", 32'h0000_0004);

    // beq at 0x10 taken -> 0x20, not taken -> 0x14
    step($urandom, 2'b11, 1'b0, 32'h0000_0010, 1, 0);
    step(32'h1000_0003, 2'b01, 1'b1, 32'h0, 0, 1);
    expect_next("beq_taken", 32'h0000_0020);
    step($urandom, 2'b11, 1'b0, 32'h0000_0010, 0, 0);
    step(32'h1000_0003, 2'b01, 1'b0, 32'h0, 2, 1);
    expect_next("beq_not_taken", 32'h0000_0014);

    // j at 0x4000_0000 -> 0x4000_0040; jr -> 0x100
    step($urandom, 2'b11, 1'b0, 32'h4000_0000, 0, 0);
    step(32'h0800_0010, 2'b10, 1'b0, 32'h0, 0, 0);
    expect_next("jump", 32'h4000_0040);
    step($urandom, 2'b11, 1'b0, 32'h0000_0100, 1, 1);
    expect_next("jr", 32'h0000_0100);

    // Wrap at the top of the address space
    step($urandom, 2'b11, 1'b0, 32'hFFFF_FFFC, 0, 0);
    step(32'h0000_0020, 2'b00, 1'b0, 32'h0, 0, 0);
    expect_next("wrap", 32'h0000_0000);

    // Stall for 5 cycles, then reset mid-wait
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_valid", 32'(inst_valid), 32'd0);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc_out, RST_PC);
    chk("midrst_ir", inst_out, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc  = RST_PC;
    expect_next("refetch", RST_PC);
    step($urandom, 2'b00, 1'b0, 32'h0, 5, 0);

    // Misaligned jr: trap build redirects to the trap vector, otherwise loaded as is
    step($urandom, 2'b11, 1'b0, 32'h0000_0102, 0, 1);
`ifdef IF_TRAP_EN
    expect_next("trap_vector", TRAP_VEC);
`else
    expect_next("misaligned_jr", 32'h0000_0102);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rs = $urandom;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      step($urandom, 2'($urandom), 1'($urandom), rs,
           $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    done = 1'b1;
    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("ir_q_empty", 32'(exp_ir_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
